// File: rtl/conv_window_mac_pkg.sv
// Shared CNN package: Q-format constant, default memory/datapath widths,
// FSM state encoding and the saturate-to-pixel-width helper.
package conv_window_mac_pkg;

   localparam int fracBits = 8;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_W    = 9;
   localparam int ACC_W    = 2*DATA_W+4;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_RUN   = 2'd1;
   localparam state_t S_DRAIN = 2'd2;
   localparam state_t S_DONE  = 2'd3;

   // Clamp a wide signed value into the signed pixel range.
   function automatic logic signed [DATA_W-1:0] sat_data(
      input logic signed [ACC_W-1:0] v
   );
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
      lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
      if (v > hi)
         return hi[DATA_W-1:0];
      else if (v < lo)
         return lo[DATA_W-1:0];
      else
         return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// Window MAC bus: start/config from the loader, RAM read port, result.
// master = loader + RAM side, slave = conv_window_mac.
interface conv_window_mac_if #(
   parameter int addressWidthImg = conv_window_mac_pkg::ADDR_W,
   parameter int dataWidthImg    = conv_window_mac_pkg::DATA_W
);

   logic                       start;
   logic                       relu_en;
   logic [dataWidthImg-1:0]    bias;
   logic [addressWidthImg-1:0] raddr;
   logic [dataWidthImg-1:0]    img_rdata;
   logic [dataWidthImg-1:0]    w_rdata;
   logic                       busy;
   logic [dataWidthImg-1:0]    result;
   logic                       result_valid;

   modport master (
      output start, relu_en, bias, img_rdata, w_rdata,
      input  raddr, busy, result, result_valid
   );

   modport slave (
      input  start, relu_en, bias, img_rdata, w_rdata,
      output raddr, busy, result, result_valid
   );

endinterface

// File: rtl/conv_window_mac_mac_sat_stage.sv
// Product register, accumulator and shift/ReLU/saturate result stage.
// Ports: clk, rst, i_load/i_bias/i_relu_en, i_mul_en, i_fin, i_img, i_w, o_result.
module mac_sat_stage
   import conv_window_mac_pkg::*;
#(
   parameter int dataWidthImg = conv_window_mac_pkg::DATA_W,
   parameter int fracBits     = conv_window_mac_pkg::fracBits
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_load,
   input  logic [dataWidthImg-1:0] i_bias,
   input  logic                    i_relu_en,
   input  logic                    i_mul_en,
   input  logic                    i_fin,
   input  logic [dataWidthImg-1:0] i_img,
   input  logic [dataWidthImg-1:0] i_w,
   output logic [dataWidthImg-1:0] o_result
);

   localparam int PW = 2*dataWidthImg;
   localparam int AW = 2*dataWidthImg+4;

   logic signed [PW-1:0]           r_prod;
   logic                           r_prod_vld;
   logic signed [AW-1:0]           r_acc;
   logic                           r_relu;
   logic [dataWidthImg-1:0]        r_result;

   logic signed [PW-1:0]           w_prod;
   logic signed [AW-1:0]           w_prod_ext;
   logic signed [AW-1:0]           w_bias_ext;
   logic signed [AW-1:0]           w_sum;
   logic signed [AW-1:0]           w_shift;
   logic signed [AW-1:0]           w_relu;

   assign w_prod = $signed(i_img) * $signed(i_w);

   assign w_prod_ext = $signed({{(AW-PW){r_prod[PW-1]}}, r_prod});

   // Bias is aligned to the product scale (Q x Q) before accumulating.
   assign w_bias_ext = $signed({{(AW-dataWidthImg-fracBits){i_bias[dataWidthImg-1]}},
                                i_bias, {fracBits{1'b0}}});

   assign w_sum   = r_acc + w_prod_ext;
   assign w_shift = w_sum >>> fracBits;
   assign w_relu  = (r_relu && w_shift[AW-1]) ? '0 : w_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod     <= '0;
         r_prod_vld <= 1'b0;
         r_acc      <= '0;
         r_relu     <= 1'b0;
         r_result   <= '0;
      end else begin
         r_prod_vld <= i_mul_en;
         if (i_mul_en)
            r_prod <= w_prod;
         if (i_load) begin
            r_acc  <= w_bias_ext;
            r_relu <= i_relu_en;
         end else if (r_prod_vld) begin
            r_acc <= w_sum;
         end
         // The drain cycle folds in the last product while forming the result.
         if (i_fin)
            r_result <= sat_data(w_relu);
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/conv_window_mac.sv
// 3x3 window dot product + bias with optional ReLU and saturation.
// Ports: clk, rst (sync, active-high), bus (conv_window_mac_if.slave).
module conv_window_mac
   import conv_window_mac_pkg::*;
#(
   parameter int numWeightImg    = conv_window_mac_pkg::NUM_W,
   parameter int addressWidthImg = conv_window_mac_pkg::ADDR_W,
   parameter int dataWidthImg    = conv_window_mac_pkg::DATA_W,
   parameter int fracBits        = conv_window_mac_pkg::fracBits
) (
   input  logic              clk,
   input  logic              rst,
   conv_window_mac_if.slave  bus
);

   state_t                     r_state;
   logic [addressWidthImg-1:0] r_cnt;

   logic w_accept;
   logic w_last;

   assign w_accept = (r_state == S_IDLE) && bus.start;
   assign w_last   = (r_cnt == addressWidthImg'(numWeightImg-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_RUN;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               if (w_last) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + addressWidthImg'(1);
               end
            end
            S_DRAIN: r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.raddr        = r_cnt;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.result_valid = (r_state == S_DONE);

   mac_sat_stage #(
      .dataWidthImg (dataWidthImg),
      .fracBits     (fracBits)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_accept),
      .i_bias    (bus.bias),
      .i_relu_en (bus.relu_en),
      .i_mul_en  (r_state == S_RUN),
      .i_fin     (r_state == S_DRAIN),
      .i_img     (bus.img_rdata),
      .i_w       (bus.w_rdata),
      .o_result  (bus.result)
   );

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Consumes one 3x3 window from the image window RAM and the matching 3x3 kernel from the weight RAM. Computes the fixed-point dot product plus bias, applies optional ReLU and saturation, and emits one output pixel with a one-cycle valid strobe. It sits directly downstream of the 9-entry window RAM and reads it through that RAM's combinational read port. It drives `busy` so the upstream window loader does not write the RAM mid-computation.

## Interface
Parameters:
- `numWeightImg`, 9: window/kernel entries read per operation.
- `addressWidthImg`, 4: read address width.
- `dataWidthImg`, 16: signed pixel, weight, bias and result width.
- `fracBits`, 8: fractional bits of the Q format, shared by pixels, weights, bias and result.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request, sampled only in IDLE.
- `relu_en`  in  1  ReLU enable, captured when `start` is accepted.
- `bias`  in  dataWidthImg  signed bias in the Q format, captured when `start` is accepted.
- `raddr`  out  addressWidthImg  read address, driven to both the window RAM and the weight RAM.
- `img_rdata`  in  dataWidthImg  signed pixel, combinational response to `raddr`.
- `w_rdata`  in  dataWidthImg  signed weight, combinational response to `raddr`.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `result`  out  dataWidthImg  signed output pixel, held until the next DONE.
- `result_valid`  out  1  one-cycle strobe, high in DONE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `raddr`=0, `busy`=0.
  - When `start`=1: capture `relu_en` and `bias`, load the accumulator with `bias` sign-extended and shifted left by `fracBits`, clear the counter, go to RUN.
- **RUN** (exactly `numWeightImg` cycles, counter k = 0..numWeightImg-1)
  - `raddr`=k.
  - The product `img_rdata*w_rdata` (signed, 2*dataWidthImg bits) is registered.
  - The product registered in the previous RUN cycle, if any, is added to the accumulator.
  - After k = numWeightImg-1, go to DRAIN.
- **DRAIN** (1 cycle)
  - Add the last product.
  - Form the result: arithmetic shift right by `fracBits` (truncate toward -inf), then ReLU if enabled (negative → 0), then saturate to [-2^(dataWidthImg-1), 2^(dataWidthImg-1)-1].
  - Register the result and go to DONE.
- **DONE** (1 cycle)
  - `result_valid`=1, then go to IDLE.
- Accumulator width is 2*dataWidthImg+4 bits (40 at defaults). No internal overflow is possible for 9 terms plus bias.
- `start` outside IDLE is ignored. It is not queued.
- Reset, at any time including mid-operation:
  - state goes to IDLE, counter and accumulator are cleared;
  - `result`=0, `result_valid`=0, `busy`=0, `raddr`=0;
  - no valid is produced for the aborted window.
- Window RAM contents are not protected by this block. The upstream loader must not write while `busy`=1.

## Timing
- `start` is sampled at edge 0 and RUN occupies cycles 1..9.
- DRAIN is cycle 10 and DONE is cycle 11 (`result_valid`=1 in cycle 11).
- Start-to-valid latency is 11 cycles. Issue rate is one window per 12 cycles; back-to-back `start` is accepted in the cycle after DONE.
- `raddr` is registered; read data is used in the same cycle `raddr` is presented.
- `result` changes only on the edge entering DONE (or on reset).

## Structure
- Shared package (same CNN package as the memory parameters):
  - the Q-format constant `fracBits`;
  - the state encoding typedef (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - a saturate-to-dataWidthImg function.
- One natural sub-module, `mac_sat_stage`: product register, accumulator, shift/ReLU/saturate. The FSM and address counter stay in `conv_window_mac`.

## Test plan
- All pixels 256, all weights 256, bias 0, ReLU off → `result`=2304 (9.0), `result_valid` exactly in cycle 11, `raddr` sequence 0..8 in cycles 1..9.
- Pixels 256, weights -256, bias 0: ReLU off → `result`=-2304 (0xF700); ReLU on → `result`=0.
- All ones (256/256) with bias 256 → `result`=2560. Bias 0x8000 with zero weights → `result`=-32768.
- Pixels and weights 0x7FFF → positive saturation `result`=0x7FFF. Pixels 0x7FFF with weights 0x8000 → `result`=0x8000.
- `start` pulsed in cycles 3 and 11 of an operation → ignored, a single `result_valid`. `start` in cycle 12 → second result valid in cycle 23.
- `rst` asserted in cycle 5 of RUN → next cycle IDLE, `busy`=0, `result`=0, no `result_valid`. A subsequent start completes normally.
